// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Brief    : Iterates a single-bit shifter to perform multi-bit logical shifts.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] sh_B,
    output logic [1:0]       Hselect,
    input  logic [WIDTH-1:0] sh_H,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_HSEL_PASS  = 2'b00;
    localparam logic [1:0] c_HSEL_RIGHT = 2'b01;
    localparam logic [1:0] c_HSEL_LEFT  = 2'b10;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (amount != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are captured once at start; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= operand;
                        r_cnt <= amount;
                        r_dir <= dir;
                    end
                end
                S_SHIFT: begin
                    r_acc <= sh_H;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_DONE:  r_result <= r_acc;
                default: ;
            endcase
        end
    end

    // The DONE cycle forwards the accumulator so the result is valid with the pulse.
    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        Hselect = c_HSEL_PASS;
        if (r_state == S_SHIFT) begin
            Hselect = r_dir ? c_HSEL_LEFT : c_HSEL_RIGHT;
        end
        result  = (r_state == S_DONE) ? r_acc : r_result;
        sh_B    = r_acc;
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Scoreboard bench for shift_sequencer with a behavioural shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             start   = 1'b0;
    logic             dir     = 1'b0;
    logic [CNT_W-1:0] amount  = '0;
    logic [WIDTH-1:0] operand = '0;
    logic [WIDTH-1:0] sh_B;
    logic [WIDTH-1:0] sh_H;
    logic [WIDTH-1:0] result;
    logic [1:0]       Hselect;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               start_cyc;
        int               done_cyc;
        logic             dir;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] held = '0;
    int               cyc = 0;
    int               ready = 0;
    int               vectors = 0;
    int               errors = 0;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dir     (dir),
        .amount  (amount),
        .operand (operand),
        .sh_B    (sh_B),
        .Hselect (Hselect),
        .sh_H    (sh_H),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Single-bit shifter seen by the sequencer
    assign sh_H = (Hselect == 2'b01) ? (sh_B >> 1) :
                  (Hselect == 2'b10) ? (sh_B << 1) : sh_B;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: derives expected cycle-level behaviour from the scoreboard head
    always @(negedge clk) begin
        logic             exp_done;
        logic             exp_busy;
        logic [1:0]       exp_hs;
        logic [WIDTH-1:0] exp_res;
        if (!rst) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
            exp_hs   = 2'b00;
            exp_res  = held;
            if (sb.size() > 0 && cyc >= sb[0].start_cyc) begin
                exp_busy = 1'b1;
                if (cyc == sb[0].done_cyc) begin
                    exp_done = 1'b1;
                    exp_res  = sb[0].res;
                end else begin
                    exp_hs = sb[0].dir ? 2'b10 : 2'b01;
                end
            end
            check("busy", WIDTH'(busy), WIDTH'(exp_busy));
            check("done", WIDTH'(done), WIDTH'(exp_done));
            check("hselect", WIDTH'(Hselect), WIDTH'(exp_hs));
            check("result", result, exp_res);
            if (exp_done) begin
                held = sb[0].res;
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs;
        operand = $urandom;
        dir     = 1'($urandom);
        amount  = CNT_W'($urandom);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] op, input logic d, input int a,
                         input int gap);
        exp_t e;
        while (cyc < ready + gap) tick();
        start   = 1'b1;
        operand = op;
        dir     = d;
        amount  = CNT_W'(a);
        e.res       = d ? (op << a) : (op >> a);
        e.start_cyc = cyc + 1;
        e.done_cyc  = cyc + 1 + a;
        e.dir       = d;
        sb.push_back(e);
        ready = e.done_cyc + 1;
        tick();
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic pulse_ignored_start;
        start = 1'b1;
        scramble_inputs();
        tick();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst   = 1'b0;
        ready = cyc;
        tick();

        do_op(32'h8000_0000, 1'b0, 31, 0);
        do_op(32'h0000_000F, 1'b1, 4, 1);
        do_op(32'hDEAD_BEEF, 1'b0, 0, 2);

        // Second start while busy (SHIFT, then DONE) must be dropped
        do_op(32'h8000_0000, 1'b1, 1, 1);
        pulse_ignored_start();
        pulse_ignored_start();

        // Abort in the fifth SHIFT cycle
        do_op(32'h1234_5678, 1'b1, 20, 2);
        repeat (4) tick();
        rst = 1'b1;
        sb.delete();
        held = '0;
        tick();
        rst   = 1'b0;
        ready = cyc;
        do_op(32'hCAFE_F00D, 1'b0, 8, 0);

        // Back-to-back: second start right after the done cycle
        do_op(32'hA5A5_A5A5, 1'b1, 5, 0);
        do_op(32'h0F0F_0F0F, 1'b0, 3, 0);
        do_op(32'hFFFF_FFFF, 1'b1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op($urandom, 1'($urandom), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) pulse_ignored_start();
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
